// File: rtl/core_seq_unit_if.sv
// core_seq_unit_if: slice-wide bus between the sequencer and the external ALU.
interface core_seq_unit_if #(parameter int SLICE_W = 8);
    logic [SLICE_W-1:0] OUT_data_a;
    logic [SLICE_W-1:0] OUT_data_b;
    logic [3:0]         OUT_ALU_OP;
    logic               OUT_carry_out;
    logic [SLICE_W-1:0] IN_S;
    logic               IN_carry_in;
    logic               IN_zero;
    modport master (output OUT_data_a, OUT_data_b, OUT_ALU_OP, OUT_carry_out,
                    input  IN_S, IN_carry_in, IN_zero);
    modport slave  (input  OUT_data_a, OUT_data_b, OUT_ALU_OP, OUT_carry_out,
                    output IN_S, IN_carry_in, IN_zero);
endinterface

// File: rtl/core_seq_unit.sv
// core_seq_unit: multi-slice arithmetic sequencer driving an external slice ALU,
// producing a sign-magnitude result, flags and a display blanking count.
module core_seq_unit #(
    parameter int SLICE_W  = 8,
    parameter int N_SLICES = 2,
    parameter int DIGITS   = 4,
    localparam int WIDTH   = SLICE_W * N_SLICES,
    localparam int OFF_W   = $clog2(DIGITS + 1)
) (
    input  logic              IN_clk,
    input  logic              IN_rst_n,
    input  logic              IN_start,
    input  logic              IN_clear,
    input  logic [WIDTH-1:0]  IN_src,
    input  logic [WIDTH-1:0]  IN_dst,
    input  logic [3:0]        IN_op,
    core_seq_unit_if.master   alu,
    output logic              OUT_busy,
    output logic              OUT_done,
    output logic [WIDTH-1:0]  OUT_value,
    output logic              OUT_neg_ans,
    output logic              OUT_less_than,
    output logic              OUT_zero,
    output logic              OUT_overflow,
    output logic              OUT_err,
    output logic [OFF_W-1:0]  OUT_off_number
);
    localparam int IDX_W = N_SLICES > 1 ? $clog2(N_SLICES) : 1;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t state, state_nx;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_r, b_r, res_r, fix_val;
    logic [3:0] op_r;
    logic carry_r, zacc, op_ok, accept, is_add, is_sub, is_cmp, chain, last, big;
    logic [OFF_W-1:0] cnt, fix_off;
    logic [63:0] p;
    assign op_ok  = IN_op >= 4'hA && IN_op <= 4'hE;
    assign accept = state == IDLE && IN_start && !IN_clear;
    assign is_add = op_r == 4'hA;
    assign is_sub = op_r == 4'hB;
    assign is_cmp = op_r == 4'hE;
    assign chain  = is_add || is_sub || is_cmp;
    assign last   = idx == IDX_W'(N_SLICES - 1);
    always_ff @(posedge IN_clk or negedge IN_rst_n)
        if (!IN_rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        OUT_busy = state == RUN || state == FIX;
        OUT_done = state == DONE;
        if (accept) state_nx = op_ok ? RUN : DONE;
        if (state == RUN && last) state_nx = FIX;
        if (state == FIX) state_nx = DONE;
        if (state == DONE) state_nx = IDLE;
    end
    // compare is a subtract whose only result is the final borrow
    assign alu.OUT_data_a    = state == RUN ? a_r[idx*SLICE_W +: SLICE_W] : '0;
    assign alu.OUT_data_b    = state == RUN ? b_r[idx*SLICE_W +: SLICE_W] : '0;
    assign alu.OUT_ALU_OP    = state == RUN ? (is_cmp ? 4'hB : op_r) : 4'h0;
    assign alu.OUT_carry_out = state == RUN && chain && idx != '0 && carry_r;
    always_comb begin
        fix_val = is_cmp ? '0 : (is_sub && carry_r) ? ~res_r + WIDTH'(1) : res_r;
        cnt = '0;
        p = 64'd1;
        for (int i = 0; i < DIGITS; i++) begin
            p = p * 64'd10;
            if (64'(fix_val) >= p) cnt = cnt + OFF_W'(1);
        end
        big = cnt == OFF_W'(DIGITS);
        fix_off = big ? '0 : OFF_W'(DIGITS - 1) - cnt;
    end
    always_ff @(posedge IN_clk or negedge IN_rst_n)
        if (!IN_rst_n) begin
            idx <= '0;
            a_r <= '0;
            b_r <= '0;
            op_r <= '0;
            res_r <= '0;
            carry_r <= 1'b0;
            zacc <= 1'b0;
            OUT_value <= '0;
            OUT_neg_ans <= 1'b0;
            OUT_less_than <= 1'b0;
            OUT_zero <= 1'b0;
            OUT_overflow <= 1'b0;
            OUT_err <= 1'b0;
            OUT_off_number <= OFF_W'(DIGITS);
        end else begin
            if (accept) begin
                a_r <= IN_src;
                b_r <= IN_dst;
                op_r <= IN_op;
                idx <= '0;
                res_r <= '0;
                carry_r <= 1'b0;
                zacc <= 1'b1;
                OUT_err <= !op_ok;
            end else if ((state == IDLE || state == DONE) && IN_clear) OUT_err <= 1'b0;
            if (accept || ((state == IDLE || state == DONE) && IN_clear)) begin
                OUT_value <= '0;
                OUT_neg_ans <= 1'b0;
                OUT_less_than <= 1'b0;
                OUT_zero <= 1'b0;
                OUT_overflow <= 1'b0;
                OUT_off_number <= OFF_W'(DIGITS);
            end
            if (state == RUN) begin
                res_r[idx*SLICE_W +: SLICE_W] <= alu.IN_S;
                carry_r <= alu.IN_carry_in;
                zacc <= zacc & alu.IN_zero;
                idx <= last ? '0 : idx + IDX_W'(1);
            end
            if (state == FIX) begin
                OUT_value <= fix_val;
                OUT_neg_ans <= is_sub && carry_r;
                OUT_less_than <= is_cmp && carry_r;
                OUT_zero <= zacc;
                OUT_overflow <= (is_add && carry_r) || big;
                OUT_off_number <= fix_off;
            end
        end
endmodule

// File: tb/tb_core_seq_unit.sv
// tb_core_seq_unit: scoreboard bench with a behavioural slice ALU; expected
// results come from a full-width reference model.
module tb_core_seq_unit;
    logic clk = 0, rst_n = 0, start = 0, clear = 0;
    logic [15:0] src = 0, dst = 0, value;
    logic [3:0] op = 0;
    logic busy, done, neg_ans, less_than, zero, overflow, err;
    logic [2:0] off_number;
    logic [8:0] alu_r;
    int checks = 0, errors = 0, c1;
    typedef struct packed {
        logic [15:0] value;
        logic neg, lt, zero, ovf, err;
        logic [2:0] off;
    } exp_t;
    exp_t sb[$];
    core_seq_unit_if #(.SLICE_W(8)) alu ();
    core_seq_unit #(.SLICE_W(8), .N_SLICES(2), .DIGITS(4)) dut (
        .IN_clk(clk), .IN_rst_n(rst_n), .IN_start(start), .IN_clear(clear),
        .IN_src(src), .IN_dst(dst), .IN_op(op), .alu(alu),
        .OUT_busy(busy), .OUT_done(done), .OUT_value(value), .OUT_neg_ans(neg_ans),
        .OUT_less_than(less_than), .OUT_zero(zero), .OUT_overflow(overflow),
        .OUT_err(err), .OUT_off_number(off_number)
    );
    always #5 clk = ~clk;
    always_comb begin
        alu_r = 9'd0;
        if (alu.OUT_ALU_OP == 4'hA)
            alu_r = {1'b0, alu.OUT_data_a} + {1'b0, alu.OUT_data_b} + {8'd0, alu.OUT_carry_out};
        else if (alu.OUT_ALU_OP == 4'hB)
            alu_r = {1'b0, alu.OUT_data_a} - {1'b0, alu.OUT_data_b} - {8'd0, alu.OUT_carry_out};
        else if (alu.OUT_ALU_OP == 4'hC) alu_r = {1'b0, alu.OUT_data_a & alu.OUT_data_b};
        else if (alu.OUT_ALU_OP == 4'hD) alu_r = {1'b0, alu.OUT_data_a | alu.OUT_data_b};
    end
    assign alu.IN_S = alu_r[7:0];
    assign alu.IN_carry_in = alu_r[8];
    assign alu.IN_zero = alu_r[7:0] == 8'd0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] o);
        exp_t e;
        logic [16:0] s;
        e = '0;
        e.off = 3'd4;
        s = {1'b0, a} + {1'b0, b};
        if (o < 4'hA || o > 4'hE) begin
            e.err = 1'b1;
            return e;
        end
        if (o == 4'hA) begin
            e.value = s[15:0];
            e.ovf = s[16];
        end
        if (o == 4'hB) begin
            e.neg = a < b;
            e.value = e.neg ? b - a : a - b;
        end
        if (o == 4'hC) e.value = a & b;
        if (o == 4'hD) e.value = a | b;
        if (o == 4'hE) e.lt = a < b;
        e.zero = o == 4'hE ? a == b : e.value == 16'd0;
        if (e.value >= 16'd10000) begin
            e.ovf = 1'b1;
            e.off = 3'd0;
        end else e.off = e.value >= 1000 ? 3'd0 : e.value >= 100 ? 3'd1 : e.value >= 10 ? 3'd2 : 3'd3;
        return e;
    endfunction
    always @(negedge clk) begin : mon
        exp_t e;
        if (done) begin
            if (sb.size() == 0) check("spurious_done", done, 0);
            else begin
                e = sb.pop_front();
                check("value", value, e.value);
                check("neg_ans", neg_ans, e.neg);
                check("less_than", less_than, e.lt);
                check("zero", zero, e.zero);
                check("overflow", overflow, e.ovf);
                check("err", err, e.err);
                check("off_number", off_number, e.off);
            end
        end
    end
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] o,
                          input int lat, input bit spam, output int carry1);
        int n, bn;
        @(negedge clk);
        src = a; dst = b; op = o; start = 1;
        sb.push_back(model(a, b, o));
        @(negedge clk);
        start = 0; n = 0; bn = 0; carry1 = 0;
        while (!done && n < 20) begin
            if (n == 1) carry1 = alu.OUT_carry_out;
            bn += busy;
            if (spam) begin
                start = 1; src = 16'($urandom); dst = 16'($urandom);
            end
            @(negedge clk);
            n++;
        end
        start = 0;
        check("latency", n, lat);
        check("busy_cycles", bn, lat);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("alu_op_idle", alu.OUT_ALU_OP, 0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_value", value, 0);
        check("rst_off", off_number, 4);
        check("rst_alu_a", alu.OUT_data_a, 0);
        check("rst_alu_op", alu.OUT_ALU_OP, 0);
        check("rst_alu_cy", alu.OUT_carry_out, 0);
        rst_n = 1;
        run_op(16'h00FF, 16'h0001, 4'hA, 3, 0, c1);
        check("add_chain_carry", c1, 1);
        run_op(16'd3, 16'd5, 4'hB, 3, 0, c1);
        run_op(16'd5, 16'd3, 4'hB, 3, 0, c1);
        run_op(16'd100, 16'd100, 4'hE, 3, 0, c1);
        run_op(16'd99, 16'd100, 4'hE, 3, 0, c1);
        run_op(16'd9000, 16'd2000, 4'hA, 3, 0, c1);
        run_op(16'hFFFF, 16'h0001, 4'hA, 3, 0, c1);
        run_op(16'h0000, 16'h0000, 4'hD, 3, 0, c1);
        run_op(16'h0F0F, 16'h00FC, 4'hC, 3, 0, c1);
        check("and_no_carry", c1, 0);
        run_op(16'h1234, 16'h0001, 4'h3, 0, 0, c1);
        run_op(16'd1, 16'd2, 4'hA, 3, 1, c1);
        repeat (4) @(negedge clk);
        check("spam_idle", busy, 0);
        check("hold_value", value, 3);
        start = 1; clear = 1; src = 16'd7; dst = 16'd8; op = 4'hA;
        @(negedge clk);
        start = 0; clear = 0;
        check("clr_busy", busy, 0);
        check("clr_value", value, 0);
        check("clr_off", off_number, 4);
        repeat (3) @(negedge clk);
        check("clr_stays_idle", busy, 0);
        run_op(16'd40, 16'd2, 4'hA, 3, 0, c1);
        @(negedge clk);
        start = 1; src = 16'd5; dst = 16'd6; op = 4'hA;
        @(negedge clk);
        start = 0;
        check("run_busy", busy, 1);
        #2 rst_n = 0;
        #1 check("midrst_busy", busy, 0);
        check("midrst_value", value, 0);
        check("midrst_off", off_number, 4);
        check("midrst_alu_op", alu.OUT_ALU_OP, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (6) @(negedge clk);
        run_op(16'd1234, 16'd0, 4'hD, 3, 0, c1);
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
